// File: rtl/ram8x16_pkg.sv
// Shared defaults and word/address types for the 8x16 dual-port RAM.
package ram8x16_pkg;

    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 8;
    localparam int ADDR_SIZE = 3;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [RAM_WIDTH-1:0] word_t;

endpackage

// File: rtl/ram8x16_parity_gen.sv
// Combinational even-parity generator over a data word.
// Only compiled when RAM_PARITY_EN is defined, the only build that uses it.
`ifdef RAM_PARITY_EN
module ram8x16_parity_gen
    import ram8x16_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Parity bit makes the total number of ones (data + parity) even.
    always_comb begin
        parity = ^data;
    end

endmodule
`endif

// File: rtl/ram8x16_asynch_dualport.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Asynchronous active-low clear wipes the array and the read register.
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word
// and flag parity mismatches on reads through parity_err.
module ram8x16_asynch_dualport #(
    parameter int RAM_WIDTH = ram8x16_pkg::RAM_WIDTH,
    parameter int RAM_DEPTH = ram8x16_pkg::RAM_DEPTH,
    parameter int ADDR_SIZE = ram8x16_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0] data_out
`ifdef RAM_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    import ram8x16_pkg::*;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Write port: store data_in at wr_addr; clear the whole array on reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Read port: registered read; sampling the array before the write lands
    // gives read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_out <= '0;
        end else if (re) begin
            data_out <= mem[rd_addr];
        end
    end

`ifdef RAM_PARITY_EN
    logic par_mem [RAM_DEPTH];
    logic wr_parity;
    logic rd_parity;

    ram8x16_parity_gen #(
        .WIDTH (RAM_WIDTH)
    ) u_wr_parity (
        .data   (data_in),
        .parity (wr_parity)
    );

    ram8x16_parity_gen #(
        .WIDTH (RAM_WIDTH)
    ) u_rd_parity (
        .data   (mem[rd_addr]),
        .parity (rd_parity)
    );

    // Parity storage tracks the data array word for word.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
                par_mem[i] <= 1'b0;
            end
        end else if (we) begin
            par_mem[wr_addr] <= wr_parity;
        end
    end

    // Parity check registered alongside data_out; holds when re is low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err <= 1'b0;
        end else if (re) begin
            parity_err <= par_mem[rd_addr] ^ rd_parity;
        end
    end
`endif

endmodule

// File: tb/tb_ram8x16_asynch_dualport.sv
// Self-checking bench for ram8x16_asynch_dualport: directed vector table,
// hand-written reset/collision sequences and a randomised scoreboard run.
module tb_ram8x16_asynch_dualport;

    import ram8x16_pkg::*;

    logic  clk;
    logic  clr_n;
    logic  we;
    logic  re;
    word_t data_in;
    addr_t rd_addr;
    addr_t wr_addr;
    word_t data_out;
`ifdef RAM_PARITY_EN
    logic  parity_err;
`endif

    ram8x16_asynch_dualport #(
        .RAM_WIDTH (16),
        .RAM_DEPTH (8),
        .ADDR_SIZE (3)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .we       (we),
        .re       (re),
        .data_in  (data_in),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .data_out (data_out)
`ifdef RAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  we;
        logic  re;
        addr_t wa;
        addr_t ra;
        word_t din;
        word_t exp;
    } vec_t;

    vec_t  vecs[$];
    word_t model [8];
    word_t exp_q[$];
    word_t held;
    int    checks;
    int    errors;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = '0;
        exp_q.delete();
        held = '0;
    endtask

    // One clock cycle of stimulus; scoreboard-checks data_out after the edge.
    task automatic drive(input logic w, input logic r, input addr_t wa,
                         input addr_t ra, input word_t d);
        @(negedge clk);
        we = w; re = r; wr_addr = wa; rd_addr = ra; data_in = d;
        if (r) exp_q.push_back(model[ra]);
        if (w) model[wa] = d;
        @(posedge clk);
        #1;
        if (r) held = exp_q.pop_front();
        check("scoreboard", data_out, held);
    endtask

    task automatic add_vec(input logic w, input logic r, input addr_t wa,
                           input addr_t ra, input word_t d, input word_t e);
        vec_t v;
        v.we = w; v.re = r; v.wa = wa; v.ra = ra; v.din = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        word_t fill [8];
        checks  = 0;
        errors  = 0;
        clr_n   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        data_in = '0;
        rd_addr = '0;
        wr_addr = '0;
        model_reset();

        fill[0] = 16'h0003; fill[1] = 16'h000A; fill[2] = 16'h0011; fill[3] = 16'h0018;
        fill[4] = 16'h001F; fill[5] = 16'h0026; fill[6] = 16'h002D; fill[7] = 16'h0034;

        // Directed vectors: fill, read back, hold, collision, independent ports.
        for (int i = 0; i < 8; i++) add_vec(1'b1, 1'b0, addr_t'(i), 3'd0, fill[i], 16'h0000);
        for (int i = 0; i < 8; i++) add_vec(1'b0, 1'b1, 3'd0, addr_t'(i), 16'h0, fill[i]);
        add_vec(1'b1, 1'b0, 3'd2, 3'd0, 16'h1234, 16'h0034);
        add_vec(1'b0, 1'b1, 3'd0, 3'd2, 16'h0000, 16'h1234);
        add_vec(1'b1, 1'b0, 3'd2, 3'd2, 16'h5555, 16'h1234);
        add_vec(1'b0, 1'b0, 3'd0, 3'd2, 16'h0000, 16'h1234);
        add_vec(1'b1, 1'b0, 3'd5, 3'd0, 16'hAAAA, 16'h1234);
        add_vec(1'b1, 1'b1, 3'd5, 3'd5, 16'h5555, 16'hAAAA);
        add_vec(1'b0, 1'b1, 3'd0, 3'd5, 16'h0000, 16'h5555);
        add_vec(1'b1, 1'b1, 3'd0, 3'd1, 16'hBEEF, 16'h000A);
        add_vec(1'b0, 1'b1, 3'd0, 3'd0, 16'h0000, 16'hBEEF);
        add_vec(1'b0, 1'b1, 3'd0, 3'd2, 16'h0000, 16'h5555);

        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", data_out, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;

        // Reset clears everything: fill with FFFF, then clear asynchronously.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, addr_t'(i), 3'd0, 16'hFFFF);
        drive(1'b0, 1'b1, 3'd0, 3'd4, 16'h0000);
        check("pre_reset_read", data_out, 16'hFFFF);
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        #2 clr_n = 1'b0;
        #1 check("async_clear_dout", data_out, 16'h0000);
        model_reset();
        @(posedge clk);
        #1 check("dout_during_reset", data_out, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 3'd0, addr_t'(i), 16'h0000);
            check("cleared_word", data_out, 16'h0000);
        end

        // Table-driven directed vectors.
        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].re, vecs[k].wa, vecs[k].ra, vecs[k].din);
            check($sformatf("vec%0d", k), data_out, vecs[k].exp);
        end

        // Async reset mid-stream: write to addr 3 in flight when clr_n drops.
        @(negedge clk);
        we = 1'b1; wr_addr = 3'd3; data_in = 16'hDEAD; re = 1'b1; rd_addr = 3'd0;
        #2 clr_n = 1'b0;
        #1 check("midstream_clear_dout", data_out, 16'h0000);
        model_reset();
        @(posedge clk);
        #1 check("midstream_hold_zero", data_out, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1; we = 1'b0; re = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 3'd3, 16'h0000);
        check("dropped_write", data_out, 16'h0000);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  addr_t'($urandom_range(0, 7)), addr_t'($urandom_range(0, 7)),
                  word_t'($urandom));
        end

`ifdef RAM_PARITY_EN
        drive(1'b1, 1'b0, 3'd1, 3'd0, 16'h0001);
        drive(1'b0, 1'b1, 3'd0, 3'd1, 16'h0000);
        check("parity_ok", {15'd0, parity_err}, 16'h0000);
        @(negedge clk);
        dut.mem[1] = 16'h0003;
        model[1] = 16'h0003;
        drive(1'b0, 1'b1, 3'd0, 3'd1, 16'h0000);
        check("parity_err", {15'd0, parity_err}, 16'h0001);
        drive(1'b0, 1'b0, 3'd0, 3'd1, 16'h0000);
        check("parity_hold", {15'd0, parity_err}, 16'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
